// File: rtl/load_store_unit.sv
// Load/store stage in front of a single-port data memory: address conversion,
// load extension and sub-word read-modify-write. Byte/half support: LSU_SUBWORD_EN.
module load_store_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [AW+1:0]    req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             misalign_err,
  output logic             mem_write,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
`ifdef LSU_SUBWORD_EN
    , WRITE = 2'd3
`endif
  } state_t;

  state_t           state_q, state_d;
  logic             wr_q;
  logic             mem_write_q, mem_write_d;
  logic             resp_valid_d, err_d, misaligned, accept;
  logic [WIDTH-1:0] resp_rdata_d, wdata_d, load_val;
  logic [AW-1:0]    addr_d;

`ifdef LSU_SUBWORD_EN
  logic [1:0]       size_q;
  logic             uns_q;
  logic [1:0]       lane_q;
  logic [15:0]      wdata_q;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic [WIDTH-1:0] lane_mask, lane_fill, merged;
`else
  logic             unused_unsigned;
  assign unused_unsigned = req_unsigned;
`endif

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;

`ifdef LSU_SUBWORD_EN
  assign misaligned = (req_size == 2'b11) ||
                      ((req_size == SZ_HALF) && req_addr[0]) ||
                      ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = (req_size != SZ_WORD) || (req_addr[1:0] != 2'b00);
`endif

  // Gated by rst_n so a store aborted by reset never reaches the memory edge.
  assign mem_write = mem_write_q & rst_n;

`ifdef LSU_SUBWORD_EN
  always_comb begin
    byte_v    = mem_rdata[{lane_q, 3'b000} +: 8];
    half_v    = mem_rdata[{lane_q[1], 4'b0000} +: 16];
    lane_mask = '0;
    lane_fill = '0;
    load_val  = mem_rdata;
    unique case (size_q)
      SZ_BYTE: begin
        load_val  = {{(WIDTH-8){~uns_q & byte_v[7]}}, byte_v};
        lane_mask = {{(WIDTH-8){1'b0}}, 8'hFF} << {lane_q, 3'b000};
        lane_fill = {(WIDTH/8){wdata_q[7:0]}};
      end
      SZ_HALF: begin
        load_val  = {{(WIDTH-16){~uns_q & half_v[15]}}, half_v};
        lane_mask = {{(WIDTH-16){1'b0}}, 16'hFFFF} << {lane_q[1], 4'b0000};
        lane_fill = {(WIDTH/16){wdata_q}};
      end
      default: ;
    endcase
    merged = (mem_rdata & ~lane_mask) | (lane_fill & lane_mask);
  end
`else
  assign load_val = mem_rdata;
`endif

  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata;
    err_d        = misalign_err;
    addr_d       = mem_addr;
    wdata_d      = mem_wdata;
    mem_write_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d       = req_addr[AW+1:2];
          resp_rdata_d = '0;
          err_d        = misaligned;
          if (misaligned) begin
            state_d      = DONE;
            resp_valid_d = 1'b1;
          end else begin
            state_d = ACCESS;
            if (req_write && (req_size == SZ_WORD)) begin
              mem_write_d = 1'b1;
              wdata_d     = req_wdata;
            end
          end
        end
      end
      ACCESS: begin
        if (!wr_q) begin
          resp_rdata_d = load_val;
          state_d      = DONE;
          resp_valid_d = 1'b1;
        end
`ifdef LSU_SUBWORD_EN
        else if (size_q != SZ_WORD) begin
          wdata_d     = merged;
          mem_write_d = 1'b1;
          state_d     = WRITE;
        end
`endif
        else begin
          state_d      = DONE;
          resp_valid_d = 1'b1;
        end
      end
`ifdef LSU_SUBWORD_EN
      WRITE: begin
        state_d      = DONE;
        resp_valid_d = 1'b1;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      misalign_err <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_write_q  <= 1'b0;
      wr_q         <= 1'b0;
`ifdef LSU_SUBWORD_EN
      size_q       <= '0;
      uns_q        <= 1'b0;
      lane_q       <= '0;
      wdata_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      resp_valid   <= resp_valid_d;
      resp_rdata   <= resp_rdata_d;
      misalign_err <= err_d;
      mem_addr     <= addr_d;
      mem_wdata    <= wdata_d;
      mem_write_q  <= mem_write_d;
      if (accept) begin
        wr_q    <= req_write;
`ifdef LSU_SUBWORD_EN
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        lane_q  <= req_addr[1:0];
        wdata_q <= req_wdata[15:0];
`endif
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a word-array reference model predicts
// responses, write cycles and final memory contents; a forked monitor checks them.
module tb_load_store_unit;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]       req_size;
  logic [AW+1:0]    req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             resp_valid, misalign_err, mem_write;
  logic [WIDTH-1:0] resp_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]    mem_addr;

  load_store_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .misalign_err(misalign_err), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // attached memory
  logic [WIDTH-1:0] tb_mem [DEPTH];
  logic             mem_init;
  assign mem_rdata = tb_mem[mem_addr];

  function automatic logic [31:0] init_val(int i);
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5AC3C3;
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) tb_mem[i] <= init_val(i);
    end else if (mem_write) begin
      tb_mem[mem_addr] <= mem_wdata;
    end
  end

  // reference model state and scoreboard queues
  typedef struct { logic [31:0] rdata; logic err; int cyc; } resp_t;
  typedef struct { logic [AW-1:0] addr; logic [31:0] data; int cyc; } wr_t;
  resp_t          rq[$];
  wr_t            wq[$];
  logic [31:0]    ref_mem [DEPTH];
  int             n_vec = 0, n_err = 0;
  int             last_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic bit legal(input logic [1:0] sz, input logic [1:0] lane);
`ifdef LSU_SUBWORD_EN
    if (sz == 2'd2) return lane == 2'd0;
    if (sz == 2'd1) return lane[0] == 1'b0;
    return sz == 2'd0;
`else
    return (sz == 2'd2) && (lane == 2'd0);
`endif
  endfunction

  // Predicts the outcome of a request accepted at edge t.
  task automatic model(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [AW+1:0] addr, input logic [31:0] wd, input int t);
    logic [AW-1:0] wa;
    int            lane;
    logic [31:0]   w, v;
    logic [7:0]    b;
    logic [15:0]   h;
    wa   = addr[AW+1:2];
    lane = int'(addr[1:0]);
    w    = ref_mem[wa];
    if (!legal(sz, addr[1:0])) begin
      rq.push_back('{32'h0, 1'b1, t + 1});
    end else if (!wr) begin
      b = w[lane*8 +: 8];
      h = w[(lane/2)*16 +: 16];
      case (sz)
        2'd0:    v = uns ? 32'(b) : 32'($signed(b));
        2'd1:    v = uns ? 32'(h) : 32'($signed(h));
        default: v = w;
      endcase
      rq.push_back('{v, 1'b0, t + 2});
    end else if (sz == 2'd2) begin
      ref_mem[wa] = wd;
      wq.push_back('{wa, wd, t + 1});
      rq.push_back('{32'h0, 1'b0, t + 2});
    end else begin
      if (sz == 2'd0) w[lane*8 +: 8] = wd[7:0];
      else            w[(lane/2)*16 +: 16] = wd[15:0];
      ref_mem[wa] = w;
      wq.push_back('{wa, w, t + 2});
      rq.push_back('{32'h0, 1'b0, t + 3});
    end
  endtask

  task automatic monitor();
    resp_t r;
    wr_t   w;
    forever begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        if (rq.size() == 0) flag("unexpected_resp");
        else begin
          r = rq.pop_front();
          chk("resp_cycle", 32'(cyc), 32'(r.cyc));
          chk("resp_rdata", resp_rdata, r.rdata);
          chk("misalign_err", 32'(misalign_err), 32'(r.err));
        end
      end
      if (mem_write === 1'b1) begin
        if (wq.size() == 0) flag("unexpected_mem_write");
        else begin
          w = wq.pop_front();
          chk("write_cycle", 32'(cyc), 32'(w.cyc));
          chk("write_addr", 32'(mem_addr), 32'(w.addr));
          chk("write_data", mem_wdata, w.data);
        end
      end
    end
  endtask

  // Presents a request (req_valid stays high afterwards) and returns at the acceptance edge.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [AW+1:0] addr, input logic [31:0] wd, input bit track);
    int waited = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_size = sz;
    req_unsigned = uns; req_addr = addr; req_wdata = wd;
    while (req_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (req_ready !== 1'b1) begin
      flag("accept_timeout");
      req_valid = 1'b0;
    end else begin
      last_t = cyc;
      if (track) model(wr, sz, uns, addr, wd, cyc);
      @(posedge clk);
    end
  endtask

  task automatic drain();
    int waited = 0;
    @(negedge clk);
    req_valid = 1'b0;
    while ((rq.size() != 0 || wq.size() != 0) && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    if (rq.size() != 0 || wq.size() != 0) begin
      flag("drain_timeout");
      rq.delete();
      wq.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int t0, t1, t2;
    rst_n = 1'b0; mem_init = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd2;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    fork monitor(); join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_misalign_err", 32'(misalign_err), 32'h0);
    chk("rst_mem_write", 32'(mem_write), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    mem_init = 1'b0;
    rst_n = 1'b1;

    // word store / load round trip
    issue(1'b1, 2'd2, 1'b0, 7'h0C, 32'h12345678, 1'b1);
    drain();
    issue(1'b0, 2'd2, 1'b0, 7'h0C, 32'h0, 1'b1);
    drain();
    // lane extraction from 0x8899AABB
    issue(1'b1, 2'd2, 1'b0, 7'h0C, 32'h8899AABB, 1'b1);
    drain();
    issue(1'b0, 2'd0, 1'b0, 7'h0D, 32'h0, 1'b1);
    drain();
    issue(1'b0, 2'd0, 1'b1, 7'h0F, 32'h0, 1'b1);
    drain();
    issue(1'b0, 2'd1, 1'b0, 7'h0C, 32'h0, 1'b1);
    drain();
    // half store merge, read back
    issue(1'b1, 2'd1, 1'b0, 7'h0E, 32'hDEAD1234, 1'b1);
    drain();
    issue(1'b0, 2'd2, 1'b0, 7'h0C, 32'h0, 1'b1);
    drain();
    // misaligned requests
    issue(1'b0, 2'd1, 1'b0, 7'h0D, 32'h0, 1'b1);
    drain();
    issue(1'b1, 2'd2, 1'b0, 7'h0E, 32'hCAFEF00D, 1'b1);
    drain();

    // reset while a store is still pending: nothing may be written or answered
`ifdef LSU_SUBWORD_EN
    issue(1'b1, 2'd0, 1'b0, 7'h15, 32'h000000EE, 1'b0);
    @(posedge clk);
`else
    issue(1'b1, 2'd2, 1'b0, 7'h14, 32'hEEEEEEEE, 1'b0);
`endif
    #1;
    rst_n = 1'b0;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_mem_write", 32'(mem_write), 32'h0);
    chk("abort_resp_valid", 32'(resp_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_req_ready", 32'(req_ready), 32'h1);
    drain();

    // back-to-back loads with req_valid held high
    issue(1'b0, 2'd2, 1'b0, 7'h0C, 32'h0, 1'b1);
    t0 = last_t;
    issue(1'b0, 2'd2, 1'b0, 7'h10, 32'h0, 1'b1);
    t1 = last_t;
    issue(1'b0, 2'd2, 1'b0, 7'h14, 32'h0, 1'b1);
    t2 = last_t;
    chk("accept_gap_1", 32'(t1 - t0), 32'd3);
    chk("accept_gap_2", 32'(t2 - t1), 32'd3);
    drain();

    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            7'($urandom_range(0, 127)), $urandom(), 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        req_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    drain();

    for (int i = 0; i < DEPTH; i++) chk($sformatf("mem_word_%0d", i), tb_mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage that sits directly upstream of the single-port data memory.
- Accepts one load/store request at a time from the execute stage over a valid/ready handshake.
- Converts byte addresses to word addresses and drives the memory's write enable, word address and write data.
- Extracts and sign/zero-extends load data; performs read-modify-write for sub-word stores; returns one response per request.

Parameters:
- WIDTH, 32, data word width; must be 32 because there are 4 byte lanes.
- DEPTH, 32, number of words in the attached memory. AW = $clog2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request; high only in IDLE.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word; 11 is illegal.
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  input  AW+2  byte address.
- req_wdata  input  WIDTH  store data, right-aligned.
- resp_valid  output  1  one-cycle response pulse.
- resp_rdata  output  WIDTH  load result; 0 for stores and errors.
- misalign_err  output  1  qualifies resp_valid: request rejected, no memory write.
- mem_write  output  1  memory write enable.
- mem_addr  output  AW  memory word address = latched req_addr[AW+1:2].
- mem_wdata  output  WIDTH  memory write data.
- mem_rdata  input  WIDTH  memory combinational read data for mem_addr.

Behaviour:
- Reset (rst_n=0 at a clk edge): state returns to IDLE. resp_valid, resp_rdata, misalign_err, mem_addr and mem_wdata all reset to 0. mem_write=0 from the first edge at which reset is sampled.
- Reset mid-operation aborts the request with no response and no further memory write. A write already committed on an earlier edge stands.
- Handshake: a request is accepted on an edge where req_valid && req_ready. All request fields are latched at acceptance. req_valid while busy is ignored (not queued).
- Byte lanes are little-endian; lane k = bits [8k+7:8k].
  - Byte access uses lane addr[1:0].
  - Half access uses lanes {2·addr[1]+1, 2·addr[1]}.
- Misaligned cases: half with addr[0]=1; word with addr[1:0]≠0; size=11.
- FSM states, with T = acceptance edge:
  - IDLE: req_ready=1. On accept, go to ACCESS; if the request is misaligned, go to DONE with the error flag set.
  - ACCESS (cycle T+1), by request type:
    - Load: capture the extracted/extended lane data from mem_rdata, then go to DONE.
    - Word store: mem_write=1 and mem_wdata=req_wdata, then go to DONE.
    - Sub-word store: capture mem_rdata merged with the new lane data into mem_wdata, then go to WRITE.
  - WRITE: mem_write=1 with the merged word, then go to DONE.
  - DONE: resp_valid=1 for exactly 1 cycle, with resp_rdata/misalign_err valid. Then go to IDLE.
- Latency (resp_valid cycle relative to T):
  - Misaligned request: T+1.
  - Load and word store: T+2.
  - Sub-word store: T+3.
- Throughput: the next request is accepted in the cycle after DONE.
- mem_write is high for exactly one cycle per successful store and never during loads, errors or reset.

Optional Feature:
- Macro: LSU_SUBWORD_EN.
- Defined: byte/half accesses are supported as described above.
- Undefined:
  - Only size=10 is legal; byte/half requests respond at T+1 with misalign_err=1 and no memory access.
  - The WRITE state and merge logic are not built.

Test Plan:
- Word store to 0x0C with data 0x12345678, then word load from 0x0C:
  - Store: mem_write=1 only at T+1 with mem_addr=3; resp_valid at T+2.
  - Load: resp_rdata=0x12345678 at T+2.
- Word 3 preloaded to 0x8899AABB:
  - Signed byte load from 0x0D returns 0xFFFFFFAA.
  - Unsigned byte load from 0x0F returns 0x00000088.
  - Signed half load from 0x0C returns 0xFFFFAABB.
- Word 3 = 0x8899AABB, half store to 0x0E with data 0xDEAD1234:
  - Memory word becomes 0x1234AABB.
  - mem_write only at T+2; resp at T+3.
- Half load from 0x0D, and separately word store to 0x0E:
  - Each responds at T+1 with misalign_err=1 and resp_rdata=0.
  - mem_write stays 0 and memory is unchanged.
- Reset during WRITE of a sub-word store:
  - mem_write=0 from the reset edge onward; memory word unchanged; no resp_valid; req_ready=1 after rst_n returns high.
- req_valid held high continuously with 3 word loads:
  - Requests are accepted every 3 cycles; resp_valid pulses once per request, in order; no request is dropped or duplicated.
